pma_tx_serializer: RTL

PMA_TX_SERIALIZER -- requirements
Module: pma_tx_serializer

---
 rtl/pma_tx_serializer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pma_tx_serializer.sv
// 10-bit code-group serializer: 2-entry input FIFO, LSB-first shift-out,
// K28.5 fill on starvation, running-disparity tracking and sticky status.
module pma_tx_serializer #(
    parameter logic [9:0] FILL_NEG = 10'h17C,
    parameter logic [9:0] FILL_POS = 10'h283
) (
    input  logic       GTX_CLK,
    input  logic       mr_main_reset,
    input  logic [9:0] PUDR,
    input  logic       PUDR_valid,
    output logic       PUDR_ready,
    input  logic       clear_status,
    output logic       tx_serial,
    output logic       group_start,
    output logic       tx_disparity,
    output logic       underrun,
    output logic       code_err
);

    localparam int unsigned GW       = 10;
    localparam int unsigned CW       = 4;
    localparam int unsigned LAST_BIT = GW - 1;

    logic [GW-1:0] fifo_mem [2];
    logic          rd_ptr;
    logic          wr_ptr;
    logic [1:0]    fifo_cnt;
    logic [1:0]    fifo_cnt_nxt;
    logic [CW-1:0] bit_cnt;
    logic [GW-1:0] shreg;
    logic          armed;

    logic          load_slot;
    logic          push;
    logic          pop;
    logic [GW-1:0] load_group;
    logic [CW-1:0] ones;
    logic          disp_nxt;
    logic          bad_group;

    function automatic logic [CW-1:0] ones_count(input logic [GW-1:0] g);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < GW; i++) n = n + CW'(g[i]);
        return n;
    endfunction

    // Shift register is a flop, so its bit 0 is the registered line bit.
    assign tx_serial = shreg[0];

    // Slot decode, FIFO bookkeeping and disparity of the group about to load.
    always_comb begin
        load_slot    = (bit_cnt == CW'(LAST_BIT));
        push         = PUDR_valid && PUDR_ready;
        pop          = load_slot && (fifo_cnt != 2'd0);
        load_group   = tx_disparity ? FILL_POS : FILL_NEG;
        if (pop) load_group = fifo_mem[rd_ptr];
        ones         = ones_count(load_group);

        fifo_cnt_nxt = fifo_cnt;
        case ({push, pop})
            2'b10:   fifo_cnt_nxt = fifo_cnt + 2'd1;
            2'b01:   fifo_cnt_nxt = fifo_cnt - 2'd1;
            default: fifo_cnt_nxt = fifo_cnt;
        endcase

        disp_nxt  = tx_disparity;
        bad_group = 1'b0;
        case (ones)
            CW'(6):  disp_nxt  = 1'b1;
            CW'(4):  disp_nxt  = 1'b0;
            CW'(5):  disp_nxt  = tx_disparity;
            default: bad_group = 1'b1;
        endcase
    end

    always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            fifo_mem[0]  <= '0;
            fifo_mem[1]  <= '0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            fifo_cnt     <= 2'd0;
            PUDR_ready   <= 1'b0;
            bit_cnt      <= CW'(LAST_BIT);
            shreg        <= FILL_NEG;
            group_start  <= 1'b0;
            tx_disparity <= 1'b0;
            underrun     <= 1'b0;
            code_err     <= 1'b0;
            armed        <= 1'b0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= PUDR;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_cnt   <= fifo_cnt_nxt;
            PUDR_ready <= (fifo_cnt_nxt < 2'd2);

            if (load_slot) begin
                bit_cnt      <= '0;
                shreg        <= load_group;
                group_start  <= 1'b1;
                tx_disparity <= disp_nxt;
                if (pop) armed <= 1'b1;
            end else begin
                bit_cnt     <= bit_cnt + CW'(1);
                shreg       <= shreg >> 1;
                group_start <= 1'b0;
            end

            // A flag being set in the same cycle wins over clear_status.
            if (load_slot && !pop && armed) underrun <= 1'b1;
            else if (clear_status)          underrun <= 1'b0;

            if (load_slot && bad_group) code_err <= 1'b1;
            else if (clear_status)      code_err <= 1'b0;
        end
    end

endmodule
